// File: rtl/control_sequencer.sv
// Microcode sequencer for a small accumulator CPU: FETCH/EXEC micro-steps 0..4 driving a 16-line control word.
// Optional single-step debug mode is enabled by defining CTRL_SINGLE_STEP_EN.
module control_sequencer #(
  parameter int AUTO_RUN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step_mode,
  input  logic        step_pulse,
`endif
  output logic [15:0] ctrl_word,
  output logic [2:0]  step,
  output logic [1:0]  state,
  output logic        instr_done,
  output logic        halted
);

  localparam logic [15:0] CW_PC_OUT    = 16'h0001;
  localparam logic [15:0] CW_PC_ADD    = 16'h0002;
  localparam logic [15:0] CW_PC_LOAD   = 16'h0004;
  localparam logic [15:0] CW_MAR_IN    = 16'h0008;
  localparam logic [15:0] CW_RAM_IN    = 16'h0010;
  localparam logic [15:0] CW_RAM_OUT   = 16'h0020;
  localparam logic [15:0] CW_IR_IN     = 16'h0040;
  localparam logic [15:0] CW_IR_OUT    = 16'h0080;
  localparam logic [15:0] CW_A_IN      = 16'h0100;
  localparam logic [15:0] CW_A_OUT     = 16'h0200;
  localparam logic [15:0] CW_B_IN      = 16'h0400;
  localparam logic [15:0] CW_ALU_OUT   = 16'h1000;
  localparam logic [15:0] CW_ALU_SUB   = 16'h2000;
  localparam logic [15:0] CW_OUTPUT_IN = 16'h4000;
  localparam logic [15:0] CW_FLAGS_IN  = 16'h8000;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_OUT = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] cw;
  logic        last;
  logic        step_legal;
  logic        advance;

  // Index of the final micro-step for each opcode; everything not listed finishes in step 2.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: last_step = 3'd4;
      OP_LDA, OP_STA: last_step = 3'd3;
      default:        last_step = 3'd2;
    endcase
  endfunction

`ifdef CTRL_SINGLE_STEP_EN
  assign advance = !step_mode || step_pulse;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    step_legal = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: step_legal = (step_q == 3'd0);
      ST_FETCH:           step_legal = (step_q <= 3'd1);
      ST_EXEC:            step_legal = (step_q >= 3'd2) && (step_q <= last_step(opcode));
      default:            step_legal = 1'b0;
    endcase
  end

  // Control-word decode; JC/JZ look at the flags only in their single exec step.
  always_comb begin
    cw   = '0;
    last = 1'b0;
    case (state_q)
      ST_FETCH: begin
        case (step_q)
          3'd0:    cw = CW_PC_OUT | CW_MAR_IN;
          3'd1:    cw = CW_RAM_OUT | CW_IR_IN | CW_PC_ADD;
          default: cw = '0;
        endcase
      end
      ST_EXEC: begin
        last = step_legal && (step_q == last_step(opcode));
        case (opcode)
          OP_LDA: begin
            if (step_q == 3'd2) cw = CW_IR_OUT | CW_MAR_IN;
            if (step_q == 3'd3) cw = CW_RAM_OUT | CW_A_IN;
          end
          OP_ADD, OP_SUB: begin
            if (step_q == 3'd2) cw = CW_IR_OUT | CW_MAR_IN;
            if (step_q == 3'd3) cw = CW_RAM_OUT | CW_B_IN;
            if (step_q == 3'd4) begin
              cw = CW_ALU_OUT | CW_A_IN | CW_FLAGS_IN;
              if (opcode == OP_SUB) cw = cw | CW_ALU_SUB;
            end
          end
          OP_OUT: if (step_q == 3'd2) cw = CW_A_OUT | CW_OUTPUT_IN;
          OP_STA: begin
            if (step_q == 3'd2) cw = CW_IR_OUT | CW_MAR_IN;
            if (step_q == 3'd3) cw = CW_A_OUT | CW_RAM_IN;
          end
          OP_JMP: if (step_q == 3'd2) cw = CW_IR_OUT | CW_PC_LOAD;
          OP_JC:  if (step_q == 3'd2 && carry_flag) cw = CW_IR_OUT | CW_PC_LOAD;
          OP_JZ:  if (step_q == 3'd2 && zero_flag) cw = CW_IR_OUT | CW_PC_LOAD;
          default: cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (!step_legal) begin
      state_d = ST_IDLE;
      step_d  = 3'd0;
    end else if (advance) begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d = ST_FETCH;
            step_d  = 3'd0;
          end
        end
        ST_FETCH: begin
          if (step_q == 3'd0) begin
            step_d = 3'd1;
          end else begin
            state_d = ST_EXEC;
            step_d  = 3'd2;
          end
        end
        ST_EXEC: begin
          if (last) begin
            step_d = 3'd0;
            if (opcode == OP_HLT) state_d = ST_HALTED;
            else if (run)         state_d = ST_FETCH;
            else                  state_d = ST_IDLE;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        default: begin
          state_d = state_q;
          step_d  = step_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (AUTO_RUN != 0) ? ST_FETCH : ST_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Outputs are silenced during reset and on stalled cycles so the datapath never sees a partial or repeated step.
  assign ctrl_word  = (rst || !advance) ? 16'h0000 : cw;
  assign instr_done = !rst && advance && last;
  assign step       = step_q;
  assign state      = state_q;
  assign halted     = (state_q == ST_HALTED);

endmodule
